// File: rtl/fb_pixel_writer.sv
// Pixel commit stage: bounds-checks and linearises pipeline pixels, queues them in a
// small FIFO, and writes them to frame-buffer RAM over a valid/ready port; also fills the screen on clear.
module fb_pixel_writer #(
  parameter int SCREEN_W   = 320,
  parameter int SCREEN_H   = 240,
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              ENB,
  input  logic [15:0]       xAddr,
  input  logic [15:0]       yAddr,
  input  logic              Write,
  input  logic [DATA_W-1:0] PIX_DATA,
  input  logic [DATA_W-1:0] BG_COLOR,
  input  logic              CLEAR,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_DATA,
  output logic              MEM_WE,
  input  logic              MEM_READY,
  output logic              BUSY,
  output logic              CLEAR_DONE,
  output logic [15:0]       DROP_OOR,
  output logic [15:0]       DROP_OVF
);

  // state    | meaning
  // ST_RUN   | accept pixels, stream FIFO to memory
  // ST_DRAIN | input ignored, finish stage 1 and FIFO before the fill
  // ST_CLEAR | write latched background colour to every screen address

  localparam int PIX_TOTAL = SCREEN_W * SCREEN_H;
  localparam int PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W     = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIX_TOTAL - 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic              s1_valid;
  logic [ADDR_W-1:0] s1_addr;
  logic [DATA_W-1:0] s1_data;

  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  fifo_cnt;
  logic              fifo_empty, fifo_full;

  logic [ADDR_W-1:0] clr_cnt;
  logic [DATA_W-1:0] bg_latched;
  logic              clear_done_q;
  logic [15:0]       drop_oor_q, drop_ovf_q;

  logic              accept, oor, push, pop, ovf_drop, clr_last;
  logic              mem_we_c;
  logic [ADDR_W-1:0] mem_addr_c;
  logic [DATA_W-1:0] mem_data_c;

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == CNT_W'(FIFO_DEPTH));

  // The cycle carrying CLEAR already belongs to the drain, so its pixel is ignored.
  assign accept   = (state == ST_RUN) && !CLEAR && ENB && Write;
  assign oor      = (32'(xAddr) >= SCREEN_W) || (32'(yAddr) >= SCREEN_H);
  assign pop      = (state != ST_CLEAR) && !fifo_empty && MEM_READY;
  assign push     = s1_valid && (!fifo_full || pop);
  assign ovf_drop = s1_valid && fifo_full && !pop;

  always_comb begin
    state_nxt  = state;
    mem_we_c   = 1'b0;
    mem_addr_c = '0;
    mem_data_c = '0;
    clr_last   = 1'b0;
    case (state)
      ST_RUN: begin
        if (CLEAR) state_nxt = ST_DRAIN;
        if (!fifo_empty) begin
          mem_we_c   = 1'b1;
          mem_addr_c = fifo_addr[rd_ptr];
          mem_data_c = fifo_data[rd_ptr];
        end
      end
      ST_DRAIN: begin
        if (!s1_valid && fifo_empty) state_nxt = ST_CLEAR;
        if (!fifo_empty) begin
          mem_we_c   = 1'b1;
          mem_addr_c = fifo_addr[rd_ptr];
          mem_data_c = fifo_data[rd_ptr];
        end
      end
      ST_CLEAR: begin
        mem_we_c   = 1'b1;
        mem_addr_c = clr_cnt;
        mem_data_c = bg_latched;
        if (MEM_READY && (clr_cnt == LAST_ADDR)) begin
          clr_last  = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) state <= ST_RUN;
    else        state <= state_nxt;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      s1_valid <= 1'b0;
      s1_addr  <= '0;
      s1_data  <= '0;
    end else begin
      s1_valid <= accept && !oor;
      if (accept && !oor) begin
        s1_addr <= ADDR_W'(32'(yAddr) * 32'(SCREEN_W) + 32'(xAddr));
        s1_data <= PIX_DATA;
      end
    end
  end

  // Storage needs no reset: the head is only visible while the FIFO is non-empty.
  always_ff @(posedge ACLK) begin
    if (push) begin
      fifo_addr[wr_ptr] <= s1_addr;
      fifo_data[wr_ptr] <= s1_data;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      clr_cnt      <= '0;
      bg_latched   <= '0;
      clear_done_q <= 1'b0;
    end else begin
      clear_done_q <= clr_last;
      if (state == ST_DRAIN && state_nxt == ST_CLEAR) begin
        bg_latched <= BG_COLOR;
        clr_cnt    <= '0;
      end else if (state == ST_CLEAR && MEM_READY) begin
        clr_cnt <= clr_last ? '0 : clr_cnt + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      drop_oor_q <= '0;
      drop_ovf_q <= '0;
    end else begin
      if (accept && oor && drop_oor_q != 16'hFFFF) drop_oor_q <= drop_oor_q + 16'd1;
      if (ovf_drop && drop_ovf_q != 16'hFFFF)      drop_ovf_q <= drop_ovf_q + 16'd1;
    end
  end

  assign MEM_WE     = mem_we_c;
  assign MEM_ADDR   = mem_addr_c;
  assign MEM_DATA   = mem_data_c;
  assign BUSY       = (state != ST_RUN);
  assign CLEAR_DONE = clear_done_q;
  assign DROP_OOR   = drop_oor_q;
  assign DROP_OVF   = drop_ovf_q;

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Directed bench for fb_pixel_writer: a full-size instance for the datapath checks and
// a 4x2 instance for the clear and reset-mid-clear checks, both fed the same stimulus.
module tb_fb_pixel_writer;

  logic        ACLK = 1'b0;
  logic        ARESET, ENB, Write, CLEAR, MEM_READY;
  logic [15:0] xAddr, yAddr;
  logic [7:0]  PIX_DATA, BG_COLOR;

  logic [16:0] b_mem_addr, s_mem_addr;
  logic [7:0]  b_mem_data, s_mem_data;
  logic        b_mem_we, s_mem_we, b_busy, s_busy, b_clear_done, s_clear_done;
  logic [15:0] b_drop_oor, s_drop_oor, b_drop_ovf, s_drop_ovf;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 ACLK = ~ACLK;

  fb_pixel_writer u_big (
    .ACLK(ACLK), .ARESET(ARESET), .ENB(ENB), .xAddr(xAddr), .yAddr(yAddr), .Write(Write),
    .PIX_DATA(PIX_DATA), .BG_COLOR(BG_COLOR), .CLEAR(CLEAR), .MEM_ADDR(b_mem_addr),
    .MEM_DATA(b_mem_data), .MEM_WE(b_mem_we), .MEM_READY(MEM_READY), .BUSY(b_busy),
    .CLEAR_DONE(b_clear_done), .DROP_OOR(b_drop_oor), .DROP_OVF(b_drop_ovf)
  );

  fb_pixel_writer #(.SCREEN_W(4), .SCREEN_H(2)) u_small (
    .ACLK(ACLK), .ARESET(ARESET), .ENB(ENB), .xAddr(xAddr), .yAddr(yAddr), .Write(Write),
    .PIX_DATA(PIX_DATA), .BG_COLOR(BG_COLOR), .CLEAR(CLEAR), .MEM_ADDR(s_mem_addr),
    .MEM_DATA(s_mem_data), .MEM_WE(s_mem_we), .MEM_READY(MEM_READY), .BUSY(s_busy),
    .CLEAR_DONE(s_clear_done), .DROP_OOR(s_drop_oor), .DROP_OVF(s_drop_ovf)
  );

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic send_pix(input int x, input int y, input logic [7:0] d);
    xAddr    = 16'(x);
    yAddr    = 16'(y);
    PIX_DATA = d;
    Write    = 1'b1;
    tick();
    Write = 1'b0;
  endtask

  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  int          done_n;
  bit          found;

  initial begin
    ARESET = 1'b1; ENB = 1'b1; Write = 1'b0; CLEAR = 1'b0; MEM_READY = 1'b1;
    xAddr = '0; yAddr = '0; PIX_DATA = '0; BG_COLOR = '0;
    tick(); tick();
    ARESET = 1'b0;

    check_vec("rst_we",    32'(b_mem_we),     0);
    check_vec("rst_addr",  32'(b_mem_addr),   0);
    check_vec("rst_data",  32'(b_mem_data),   0);
    check_vec("rst_busy",  32'(b_busy),       0);
    check_vec("rst_done",  32'(b_clear_done), 0);
    check_vec("rst_oor",   32'(b_drop_oor),   0);
    check_vec("rst_ovf",   32'(b_drop_ovf),   0);

    // single pixel: accepted at t, MEM_WE exactly in t+2
    send_pix(5, 2, 8'hAB);
    check_vec("basic_we_t1", 32'(b_mem_we), 0);
    tick();
    check_vec("basic_we_t2", 32'(b_mem_we),   1);
    check_vec("basic_addr",  32'(b_mem_addr), 645);
    check_vec("basic_data",  32'(b_mem_data), 32'hAB);
    tick();
    check_vec("basic_we_t3", 32'(b_mem_we),   0);
    check_vec("basic_oor",   32'(b_drop_oor), 0);

    // ENB low gates acceptance
    ENB = 1'b0;
    send_pix(7, 7, 8'h99);
    tick(); tick();
    check_vec("enb_low_we", 32'(b_mem_we), 0);
    ENB = 1'b1;

    // out-of-range rejection, then far corner
    send_pix(320, 0, 8'h01);
    check_vec("oor_we_a", 32'(b_mem_we), 0);
    send_pix(0, 240, 8'h02);
    tick();
    check_vec("oor_we_b", 32'(b_mem_we), 0);
    tick();
    check_vec("oor_we_c", 32'(b_mem_we),   0);
    check_vec("oor_cnt",  32'(b_drop_oor), 2);
    send_pix(319, 239, 8'h77);
    tick();
    check_vec("corner_we",   32'(b_mem_we),   1);
    check_vec("corner_addr", 32'(b_mem_addr), 76799);
    check_vec("corner_data", 32'(b_mem_data), 32'h77);
    tick();

    // overflow under stall
    MEM_READY = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      xAddr = 16'(i); yAddr = 16'd0; PIX_DATA = 8'(i); Write = 1'b1;
      tick();
    end
    Write = 1'b0;
    tick();
    check_vec("ovf_cnt",   32'(b_drop_ovf), 2);
    check_vec("stall_we",  32'(b_mem_we),   1);
    check_vec("stall_d1",  32'(b_mem_data), 1);
    tick();
    check_vec("stall_d2",  32'(b_mem_data), 1);
    check_vec("stall_a2",  32'(b_mem_addr), 1);
    MEM_READY = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check_vec("ovf_drain_we",   32'(b_mem_we),   1);
      check_vec("ovf_drain_data", 32'(b_mem_data), 32'(i));
      check_vec("ovf_drain_addr", 32'(b_mem_addr), 32'(i));
      tick();
    end
    check_vec("ovf_drain_end", 32'(b_mem_we), 0);

    // full FIFO with simultaneous push and pop
    MEM_READY = 1'b0;
    for (int i = 0; i < 5; i++) begin
      xAddr = 16'(10 + i); yAddr = 16'd0; PIX_DATA = 8'(11 + i); Write = 1'b1;
      tick();
    end
    Write     = 1'b0;
    MEM_READY = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check_vec("pp_we",   32'(b_mem_we),   1);
      check_vec("pp_data", 32'(b_mem_data), 32'(11 + i));
      tick();
    end
    check_vec("pp_end_we", 32'(b_mem_we),   0);
    check_vec("pp_ovf",    32'(b_drop_ovf), 2);

    // clear sequence on the 4x2 instance
    ARESET = 1'b1; tick(); ARESET = 1'b0;
    MEM_READY = 1'b0;
    BG_COLOR  = 8'h3C;
    send_pix(1, 0, 8'hA1);
    send_pix(2, 1, 8'hA2);
    tick();
    check_vec("clr_pend_we",   32'(s_mem_we),   1);
    check_vec("clr_pend_data", 32'(s_mem_data), 32'hA1);
    CLEAR = 1'b1; tick(); CLEAR = 1'b0;
    check_vec("clr_busy_rise", 32'(s_busy), 1);
    MEM_READY = 1'b1;
    done_n = 0;
    got_q.delete();
    for (int c = 0; c < 40; c++) begin
      if (s_mem_we) got_q.push_back({7'd0, s_mem_addr, s_mem_data});
      if (s_clear_done) begin
        done_n++;
        check_vec("clr_busy_at_done", 32'(s_busy), 0);
      end
      Write = s_busy; xAddr = 16'd3; yAddr = 16'd1; PIX_DATA = 8'hEE;
      tick();
    end
    Write = 1'b0;
    exp_q.delete();
    exp_q.push_back({7'd0, 17'd1, 8'hA1});
    exp_q.push_back({7'd0, 17'd6, 8'hA2});
    for (int a = 0; a < 8; a++) exp_q.push_back({7'd0, 17'(a), 8'h3C});
    check_vec("clr_len", 32'(got_q.size()), 10);
    for (int i = 0; i < 10 && i < got_q.size(); i++) check_vec("clr_write", got_q[i], exp_q[i]);
    check_vec("clr_done_n", 32'(done_n),     1);
    check_vec("clr_busy",   32'(s_busy),     0);
    check_vec("clr_oor",    32'(s_drop_oor), 0);
    check_vec("clr_ovf",    32'(s_drop_ovf), 0);

    // reset in the middle of a clear
    send_pix(9, 0, 8'h11);
    tick();
    check_vec("mid_oor_pre", 32'(s_drop_oor), 1);
    CLEAR = 1'b1; tick(); CLEAR = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (s_mem_we && s_busy && s_mem_addr == 17'd3) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check_vec("mid_reach_addr3", 32'(found), 1);
    ARESET = 1'b1; tick(); ARESET = 1'b0;
    check_vec("mid_we",   32'(s_mem_we),     0);
    check_vec("mid_busy", 32'(s_busy),       0);
    check_vec("mid_oor",  32'(s_drop_oor),   0);
    check_vec("mid_ovf",  32'(s_drop_ovf),   0);
    check_vec("mid_done", 32'(s_clear_done), 0);
    send_pix(1, 1, 8'h5A);
    tick();
    check_vec("post_we",   32'(s_mem_we),   1);
    check_vec("post_addr", 32'(s_mem_addr), 5);
    check_vec("post_data", 32'(s_mem_data), 32'h5A);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/fb_pixel_writer.md
# fb_pixel_writer

Consumes the transformed-pixel stream from the transformation pipeline (`xAddr`, `yAddr`, `Write`) and commits each pixel to the frame buffer memory.
- Bounds-checks coordinates, linearises them to `y*SCREEN_W + x`, and buffers them in a small FIFO.
- Drives a valid/ready write port toward frame-buffer RAM.
- Provides a hardware screen-clear sequence.
- Sits between the pipeline output and the frame buffer.

## Interface
- `SCREEN_W`, 320, visible width in pixels
- `SCREEN_H`, 240, visible height in pixels
- `ADDR_W`, 17, memory address width; must satisfy `2^ADDR_W >= SCREEN_W*SCREEN_H`
- `DATA_W`, 8, pixel data width
- `FIFO_DEPTH`, 4, write FIFO entries; power of two, ≥2

Ports:
- `ACLK` in 1 — single clock, all logic on rising edge
- `ARESET` in 1 — synchronous, active-high reset
- `ENB` in 1 — input-side enable; gates acceptance of `Write` only
- `xAddr` in 16 — pixel X, unsigned
- `yAddr` in 16 — pixel Y, unsigned
- `Write` in 1 — pixel valid, sampled with `ENB`
- `PIX_DATA` in DATA_W — pixel value, sampled with `Write`
- `BG_COLOR` in DATA_W — fill value for clear; sampled at clear start
- `CLEAR` in 1 — one-cycle clear request
- `MEM_ADDR` out ADDR_W — linear write address
- `MEM_DATA` out DATA_W — write data
- `MEM_WE` out 1 — write valid
- `MEM_READY` in 1 — memory accepts when `MEM_WE & MEM_READY`
- `BUSY` out 1 — high in DRAIN or CLEAR state
- `CLEAR_DONE` out 1 — one-cycle pulse at clear completion
- `DROP_OOR` out 16 — out-of-range drop count, saturating
- `DROP_OVF` out 16 — FIFO-overflow drop count, saturating

## Operation
- States: RUN, DRAIN, CLEAR. Reset enters RUN.
- **RUN, stage 1 (input register):**
  - Accepts when `ENB & Write`.
  - If `xAddr >= SCREEN_W` or `yAddr >= SCREEN_H`, the pixel is discarded and `DROP_OOR` increments.
  - Otherwise stage 1 registers `addr = yAddr*SCREEN_W + xAddr` (truncated to ADDR_W) with `PIX_DATA`, and sets `s1_valid`.
- **Stage 2 (FIFO push):**
  - `s1_valid` pushes into the FIFO unless the FIFO is full with no pop that cycle.
  - In that case the entry is discarded and `DROP_OVF` increments.
  - A push and a pop in the same cycle on a full FIFO is legal; no drop occurs.
- **Memory port:**
  - `MEM_WE = !fifo_empty` in RUN/DRAIN; `MEM_ADDR`/`MEM_DATA` reflect the FIFO head.
  - Once raised, `MEM_WE`, `MEM_ADDR` and `MEM_DATA` stay stable until `MEM_READY`.
  - Pop occurs on `MEM_WE & MEM_READY`. Writes leave in input order.
- **CLEAR in RUN:** goes to DRAIN.
  - From that cycle on, input is ignored (not counted as a drop).
  - DRAIN completes `s1_valid` and FIFO writes normally.
  - When `s1_valid` is 0 and the FIFO is empty, the block enters CLEAR and latches `BG_COLOR`.
- **CLEAR state:**
  - An internal counter drives `MEM_ADDR` = 0, 1, … `SCREEN_W*SCREEN_H-1` with the latched BG_COLOR, one address per handshake.
  - After the last handshake: `CLEAR_DONE` pulses for the next cycle, then return to RUN.
- `CLEAR` asserted in DRAIN or CLEAR is ignored.
- Counters saturate at 0xFFFF and never wrap. If both drop types could occur in one cycle they are evaluated independently, each increments by at most 1 per cycle.
- `ENB` low does not stall the memory side; the FIFO continues draining.
- `ARESET` at any point, including mid-clear:
  - state → RUN, FIFO and stage 1 emptied, clear counter zeroed.
  - All outputs → 0; counters → 0.
  - No partial handshake is completed.

## Timing
- Reset values: `MEM_WE=0`, `MEM_ADDR=0`, `MEM_DATA=0`, `BUSY=0`, `CLEAR_DONE=0`, `DROP_OOR=0`, `DROP_OVF=0`.
- Input latency: a pixel accepted at edge t is in stage 1 after t, in the FIFO after t+1, and `MEM_WE` is high in cycle t+2 (FIFO previously empty).
- Throughput: 1 pixel/cycle sustained when `MEM_READY=1`.
- `BUSY` rises the cycle after `CLEAR` is sampled and falls together with the `CLEAR_DONE` pulse.
- Clear duration with `MEM_READY=1`: `SCREEN_W*SCREEN_H` cycles of `MEM_WE`, after any drain.
- Counter increments are visible the cycle after the drop decision.

## Test plan
- **Single pixel, basic path.** Defaults, `MEM_READY=1`; `x=5, y=2, PIX_DATA=0xAB` at cycle t → `MEM_WE` high exactly in cycle t+2 with `MEM_ADDR=645` and `MEM_DATA=0xAB`; no drops.
- **Out-of-range rejection.** Inputs `x=320,y=0` and `x=0,y=240` → no `MEM_WE`, `DROP_OOR=2`. Then `x=319,y=239` → `MEM_ADDR=76799`.
- **Overflow and stall.** `MEM_READY=0`; 6 back-to-back pixels with data 1..6 → FIFO holds 1..4, `DROP_OVF=2`, `MEM_WE` stable at data 1. Then `MEM_READY=1` → writes 1,2,3,4 on consecutive cycles.
- **Full-FIFO push and pop in the same cycle.** With the FIFO full and `MEM_READY` toggled to 1 while a 5th pixel arrives → no drop; order is preserved.
- **Clear sequence.** Set `SCREEN_W=4`, `SCREEN_H=2`, `BG_COLOR=0x3C`, and issue `CLEAR` with 2 pixels pending:
  - the 2 pending pixels are written first;
  - then addresses 0..7 are written with 0x3C;
  - `CLEAR_DONE` pulses once;
  - `Write` pulses during `BUSY` produce nothing and no counter change.
- **Reset mid-clear.** Assert `ARESET` at clear address 3 → next cycle `MEM_WE=0`, `BUSY=0`, counters 0. A subsequent pixel `x=1,y=1` writes to address 5.
